// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the configuration-register write arbiter:
// FSM encoding, default data width and the round-robin pointer helper.
package reg_write_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int DW_DEFAULT = 32;

   // Index that follows idx in a ring of n requesters.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, searching upward and wrapping. Shared with the command arbiter.
module rr_priority_pick #(
   parameter int NREQ = 2,
   parameter int PW   = 1
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] win_o,
   output logic [PW-1:0]   win_idx_o,
   output logic            any_o
);

   int   cand_s;
   logic found_s;

   // Walk the ring once starting at the pointer; the first hit wins.
   always_comb begin
      win_o     = '0;
      win_idx_o = '0;
      found_s   = 1'b0;
      cand_s    = 0;
      for (int k = 0; k < NREQ; k++) begin
         cand_s = (int'(ptr_i) + k) % NREQ;
         if (!found_s && req_i[cand_s]) begin
            found_s        = 1'b1;
            win_o[cand_s]  = 1'b1;
            win_idx_o      = PW'(cand_s);
         end else begin
            found_s = found_s;
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one configuration register between NREQ
// writers; writes are held off while the PHY is busy and verified by readback.
module reg_write_arbiter
   import reg_write_arbiter_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int DW   = DW_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    ack,
   output logic               err,
   output logic [NREQ-1:0]    grant,
   input  logic               phy_busy,
   output logic               reg_wren,
   output logic [DW-1:0]      reg_data,
   input  logic [DW-1:0]      reg_q
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_e            state_q, state_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [PW-1:0]     gidx_q, gidx_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic              err_q, err_d;
   logic              wren_q, wren_d;
   logic [DW-1:0]     data_q, data_d;

   logic [NREQ-1:0]   pick_win_s;
   logic [PW-1:0]     pick_idx_s;
   logic              pick_any_s;

   rr_priority_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .req_i     (req),
      .ptr_i     (ptr_q),
      .win_o     (pick_win_s),
      .win_idx_o (pick_idx_s),
      .any_o     (pick_any_s)
   );

   // Next-state and registered-output logic. The wren pulse lands while the
   // FSM sits in CHECK, so the register has captured by the time DONE
   // compares the readback and reports the result alongside ack.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gidx_d  = gidx_q;
      grant_d = grant_q;
      ack_d   = '0;
      err_d   = 1'b0;
      wren_d  = 1'b0;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            grant_d = '0;
            if (pick_any_s && !phy_busy) begin
               grant_d = pick_win_s;
               gidx_d  = pick_idx_s;
               data_d  = req_data[int'(pick_idx_s)*DW +: DW];
               state_d = ST_WRITE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
            wren_d  = 1'b1;
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            ack_d   = grant_q;
            err_d   = (reg_q != data_q);
            ptr_d   = PW'(rr_next(int'(gidx_q), NREQ));
            grant_d = '0;
            state_d = ST_IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         gidx_q  <= '0;
         grant_q <= '0;
         ack_q   <= '0;
         err_q   <= 1'b0;
         wren_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         wren_q  <= wren_d;
         data_q  <= data_d;
      end
   end

   assign grant    = grant_q;
   assign ack      = ack_q;
   assign err      = err_q;
   assign reg_wren = wren_q;
   assign reg_data = data_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: directed stimulus pushes expected
// writes/acks into queues; a negedge monitor pops and compares.
module tb_reg_write_arbiter;

   localparam int NREQ = 2;
   localparam int DW   = 32;

   logic               clk = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    ack;
   logic               err;
   logic [NREQ-1:0]    grant;
   logic               phy_busy;
   logic               reg_wren;
   logic [DW-1:0]      reg_data;
   logic [DW-1:0]      reg_q;

   logic [DW-1:0]      reg_val = '0;
   logic               force_zero;

   logic [DW-1:0]      wr_exp[$];
   logic [2:0]         ack_exp[$];
   logic [DW-1:0]      mon_wr;
   logic [2:0]         mon_ack;

   int n_cmp = 0;
   int n_bad = 0;

   reg_write_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
      .ack      (ack),
      .err      (err),
      .grant    (grant),
      .phy_busy (phy_busy),
      .reg_wren (reg_wren),
      .reg_data (reg_data),
      .reg_q    (reg_q)
   );

   always #5 clk = ~clk;

   // Behavioural register_rw, with a fault hook that zeroes the readback.
   always @(posedge clk) begin
      if (reg_wren) reg_val <= reg_data;
   end
   assign reg_q = force_zero ? '0 : reg_val;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every write pulse and every ack is matched against the queues.
   always @(negedge clk) begin
      if (rst) begin
         if (reg_wren) begin
            if (wr_exp.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL wr_unexpected: got write of %h, required none", reg_data);
            end else begin
               mon_wr = wr_exp.pop_front();
               chk("wr_data", reg_data, mon_wr);
            end
         end
         if (ack != '0) begin
            if (ack_exp.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL ack_unexpected: got ack=%b err=%b, required none", ack, err);
            end else begin
               mon_ack = ack_exp.pop_front();
               chk("ack_err", {ack, err}, mon_ack);
            end
         end
      end
   end

   initial begin
      #200000;
      n_bad++;
      $display("FAIL watchdog: got timeout, required completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b0;
      req        = '0;
      req_data   = '0;
      phy_busy   = 1'b0;
      force_zero = 1'b0;
      repeat (3) tick();
      chk("rst_grant", grant, 2'b00);
      chk("rst_ack", ack, 2'b00);
      chk("rst_err", err, 1'b0);
      chk("rst_wren", reg_wren, 1'b0);
      chk("rst_data", reg_data, 32'h0);
      rst = 1'b1;
      tick();
      chk("idle_grant", grant, 2'b00);

      // Single write from requester 0; slice 1 carries junk.
      req      = 2'b01;
      req_data = {32'hxxxx_xxxx, 32'h8000_0000};
      wr_exp.push_back(32'h8000_0000);
      ack_exp.push_back({2'b01, 1'b0});
      tick();
      chk("t1_grant", grant, 2'b01);
      chk("t1_wren_early", reg_wren, 1'b0);
      tick();
      chk("t1_wren", reg_wren, 1'b1);
      tick();
      chk("t1_wren_width", reg_wren, 1'b0);
      chk("t1_ack_early", ack, 2'b00);
      tick();
      chk("t1_ack", ack, 2'b01);
      chk("t1_grant_clr", grant, 2'b00);
      req = 2'b00;
      tick();
      chk("t1_ack_width", ack, 2'b00);

      // Hold-off while the PHY is busy, then busy rising mid-sequence.
      req      = 2'b10;
      req_data = {32'h0000_00C3, 32'h0};
      phy_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_busy_grant", grant, 2'b00);
         chk("t3_busy_wren", reg_wren, 1'b0);
      end
      phy_busy = 1'b0;
      wr_exp.push_back(32'h0000_00C3);
      ack_exp.push_back({2'b10, 1'b0});
      tick();
      chk("t3_grant", grant, 2'b10);
      phy_busy = 1'b1;
      repeat (3) tick();
      chk("t3_ack", ack, 2'b10);
      req      = 2'b00;
      phy_busy = 1'b0;
      tick();

      // Readback fault, then a clean write must report no error.
      req        = 2'b01;
      req_data   = {32'h0, 32'hDEAD_BEEF};
      force_zero = 1'b1;
      wr_exp.push_back(32'hDEAD_BEEF);
      ack_exp.push_back({2'b01, 1'b1});
      tick();
      chk("t4_grant", grant, 2'b01);
      repeat (3) tick();
      chk("t4_err", err, 1'b1);
      req        = 2'b00;
      force_zero = 1'b0;
      tick();
      req      = 2'b10;
      req_data = {32'h0000_1234, 32'h0};
      wr_exp.push_back(32'h0000_1234);
      ack_exp.push_back({2'b10, 1'b0});
      tick();
      chk("t4b_grant", grant, 2'b10);
      repeat (3) tick();
      chk("t4b_err", err, 1'b0);
      req = 2'b00;
      tick();

      // Requester 0 withdraws during CHECK; the ack still comes.
      req      = 2'b01;
      req_data = {32'h0, 32'h5555_AAAA};
      wr_exp.push_back(32'h5555_AAAA);
      ack_exp.push_back({2'b01, 1'b0});
      tick();
      chk("t6_grant", grant, 2'b01);
      tick();
      req = 2'b00;
      repeat (2) tick();
      chk("t6_ack", ack, 2'b01);
      chk("t6_data_held", reg_data, 32'h5555_AAAA);
      tick();
      chk("t6_idle_grant", grant, 2'b00);
      tick();
      chk("t6_no_regrant", grant, 2'b00);

      // Async reset while the write pulse is high.
      req      = 2'b10;
      req_data = {32'h0BAD_0BAD, 32'h0};
      tick();
      chk("t5_grant", grant, 2'b10);
      tick();
      chk("t5_wren", reg_wren, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("t5_rst_wren", reg_wren, 1'b0);
      chk("t5_rst_grant", grant, 2'b00);
      chk("t5_rst_ack", ack, 2'b00);
      req      = 2'b11;
      req_data = {32'h0000_0002, 32'h0000_0001};
      repeat (2) tick();
      chk("t5_hold_grant", grant, 2'b00);
      rst = 1'b1;

      // Contention after reset: pointer back at 0, so order 0,1,0,1.
      for (int g = 0; g < 4; g++) begin
         wr_exp.push_back((g % 2 == 0) ? 32'h0000_0001 : 32'h0000_0002);
         ack_exp.push_back((g % 2 == 0) ? {2'b01, 1'b0} : {2'b10, 1'b0});
      end
      for (int g = 0; g < 4; g++) begin
         tick();
         chk("t2_grant", grant, (g % 2 == 0) ? 2'b01 : 2'b10);
         repeat (3) tick();
         chk("t2_ack", ack, (g % 2 == 0) ? 2'b01 : 2'b10);
         if (g == 3) req = 2'b00;
      end
      repeat (3) tick();
      chk("final_grant", grant, 2'b00);
      chk("wr_queue_drained", wr_exp.size(), 0);
      chk("ack_queue_drained", ack_exp.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares one 32-bit configuration register (a `register_rw` instance: wren/data_in write port) between NREQ requesters in the HyperRAM controller, e.g. the Wishbone config slave and the power-up init sequencer.
- Round-robin arbitration.
- Writes are held off while the HyperRAM PHY is mid-transaction.
- Each write is verified by readback before the requester is acknowledged.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DW, 32, register data width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- req  input  NREQ  per-requester write request; level, held until ack.
- req_data  input  NREQ*DW  per-requester write data; slice i = bits [i*DW +: DW]; stable while req[i]=1.
- ack  output  NREQ  one-cycle done pulse to the granted requester.
- err  output  1  valid with ack; 1 = readback mismatch.
- grant  output  NREQ  one-hot current owner; 0 when idle.
- phy_busy  input  1  HyperRAM transaction in progress; no register write may start while 1.
- reg_wren  output  1  to register_rw wren.
- reg_data  output  DW  to register_rw data_in.
- reg_q  input  DW  register_rw current value (readback).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; grant=0, ack=0, err=0, reg_wren=0, reg_data=0.
  - Round-robin pointer=0, i.e. requester 0 has highest priority first.
- All outputs are registered.
- FSM states: IDLE, WRITE, CHECK, DONE.
- IDLE:
  - If any req=1 and phy_busy=0: select the first requester at or after the pointer, searching upward and wrapping from NREQ-1 to 0.
  - Set grant one-hot and latch its data into reg_data. Next state is WRITE.
  - If phy_busy=1: stay in IDLE, grant=0.
- WRITE: reg_wren=1 for exactly one cycle, reg_data held. Next state is CHECK.
- CHECK (register has now captured the data):
  - Compare reg_q with reg_data; a mismatch sets a sticky internal mismatch flag for this transaction.
  - Next state is DONE.
- DONE:
  - ack[granted]=1 for one cycle, and err=mismatch in the same cycle.
  - Pointer becomes (granted+1) mod NREQ.
  - grant clears. Next state is IDLE.
- Latency: req sampled in IDLE at edge N gives reg_wren high during cycle N+1 and ack high during cycle N+3. Minimum 4 cycles between consecutive grants (IDLE must be revisited).
- phy_busy only gates the IDLE→WRITE transition. Once a grant is made, the sequence completes even if phy_busy rises.
- Requester drops req while granted: the sequence still completes and the ack pulse is issued (the requester ignores it). Data is already latched.
- Simultaneous requests: the round-robin order guarantees each active requester is served within NREQ grants. No starvation.
- Same requester re-asserting req immediately after its ack loses to any other pending requester.
- Reset mid-operation: the FSM returns to IDLE immediately. reg_wren drops asynchronously and no ack is issued. A partial write cannot occur because wren is a single-cycle registered pulse.
- X on req_data of non-requesting slices has no effect.

Decomposition:
- Shared package holds:
  - FSM state encoding: ST_IDLE=2'd0, ST_WRITE=2'd1, ST_CHECK=2'd2, ST_DONE=2'd3.
  - Default DW=32.
- One natural sub-module, `rr_priority_pick`:
  - Combinational.
  - Inputs: req[NREQ] and pointer.
  - Outputs: one-hot winner and its index.
  - Reused later by the HyperRAM command arbiter.

Test Plan:
- Single write: req=2'b01, req_data[31:0]=32'h8000_0000, phy_busy=0 → grant=01 next cycle, reg_wren pulse one cycle later with reg_data=32'h8000_0000, ack=01 with err=0 three cycles after req sampled.
- Contention: req=2'b11 held, data0=32'h1, data1=32'h2 → grants in order 0,1,0,1. Register values are 1,2,1,2. Each ack is 1 cycle wide and aligned to its owner.
- Hold-off: phy_busy=1 with req=2'b10 for 5 cycles → no grant, reg_wren=0. Drop phy_busy → grant=10 next cycle. Raising phy_busy during WRITE does not abort; ack still arrives.
- Readback fault: force reg_q=32'h0 while writing 32'hDEAD_BEEF → ack with err=1. The next clean write reports err=0 (flag not sticky across transactions).
- Async reset mid-WRITE: pull rst low between edges → reg_wren, grant and ack are 0 immediately. After release, pointer=0 and a pending req=2'b11 grants requester 0 first.
- Withdrawn request: requester 0 deasserts req during CHECK → ack[0] still pulses once. The register holds the latched data. The FSM returns to IDLE.
